// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - core-facing signal bundle of the interrupt entry sequencer
interface interrupt_sequencer_if;
  logic        int_req;
  logic        branch_ex;
  logic        call_busy;
  logic        ret_busy;
  logic        rti_done;
  logic [31:0] return_pc;
  logic        fd_enable;
  logic        force_nop;
  logic        int_signal;
  logic [1:0]  int_counter;
  logic        push_pc;
  logic        push_ccr;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic [31:0] saved_pc;
  logic        in_isr;

  modport master (
    input  int_req, branch_ex, call_busy, ret_busy, rti_done, return_pc,
    output fd_enable, force_nop, int_signal, int_counter, push_pc, push_ccr,
           pc_load, pc_load_value, saved_pc, in_isr
  );

  modport slave (
    output int_req, branch_ex, call_busy, ret_busy, rti_done, return_pc,
    input  fd_enable, force_nop, int_signal, int_counter, push_pc, push_ccr,
           pc_load, pc_load_value, saved_pc, in_isr
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - cycle-exact external interrupt entry: drain, push PC/CCR, vector
module interrupt_sequencer #(
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0001,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic                   clk,
  input logic                   reset,
  interrupt_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PC,
    S_PUSH_CCR,
    S_VECTOR
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        int_prev_q, int_prev_d;
  logic        in_isr_q, in_isr_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic        fd_enable_q, fd_enable_d;
  logic        force_nop_q, force_nop_d;
  logic        int_signal_q, int_signal_d;
  logic [1:0]  int_counter_q, int_counter_d;
  logic        push_pc_q, push_pc_d;
  logic        push_ccr_q, push_ccr_d;
  logic        pc_load_q, pc_load_d;
  logic [31:0] pc_load_value_q, pc_load_value_d;
  logic        req_rise;
  logic        accept;

  always_comb begin
    req_rise   = bus.int_req & ~int_prev_q;
    accept     = (state_q == S_IDLE) & pending_q & ~in_isr_q &
                 ~bus.branch_ex & ~bus.call_busy & ~bus.ret_busy;
    int_prev_d = bus.int_req;
    // An edge arriving on the acceptance edge is absorbed into the request being taken.
    pending_d  = accept ? 1'b0 : (pending_q | req_rise);
    state_d    = state_q;
    cnt_d      = cnt_q;
    saved_pc_d = saved_pc_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_DRAIN;
          cnt_d      = 2'd0;
          saved_pc_d = bus.return_pc;
        end
      end
      S_DRAIN: begin
        if (cnt_q != DRAIN_LAST) cnt_d = cnt_q + 2'd1;
        else                     state_d = S_PUSH_PC;
      end
      S_PUSH_PC:  state_d = S_PUSH_CCR;
      S_PUSH_CCR: state_d = S_VECTOR;
      S_VECTOR:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (state_q == S_VECTOR) in_isr_d = 1'b1;
    else if (bus.rti_done)   in_isr_d = 1'b0;
    else                     in_isr_d = in_isr_q;

    // Outputs decoded from the next state so the registered copies line up with state_q.
    fd_enable_d     = (state_d == S_IDLE) || (state_d == S_VECTOR);
    force_nop_d     = (state_d != S_IDLE);
    int_signal_d    = (state_d == S_DRAIN) || (state_d == S_PUSH_PC) || (state_d == S_PUSH_CCR);
    push_pc_d       = (state_d == S_PUSH_PC);
    push_ccr_d      = (state_d == S_PUSH_CCR);
    pc_load_d       = (state_d == S_VECTOR);
    pc_load_value_d = pc_load_d ? INT_VECTOR : 32'h0;
    case (state_d)
      S_DRAIN:    int_counter_d = cnt_d;
      S_PUSH_PC:  int_counter_d = 2'd2;
      S_PUSH_CCR: int_counter_d = 2'd3;
      default:    int_counter_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= 2'd0;
      pending_q       <= 1'b0;
      int_prev_q      <= bus.int_req;
      in_isr_q        <= 1'b0;
      saved_pc_q      <= 32'h0;
      fd_enable_q     <= 1'b1;
      force_nop_q     <= 1'b0;
      int_signal_q    <= 1'b0;
      int_counter_q   <= 2'd0;
      push_pc_q       <= 1'b0;
      push_ccr_q      <= 1'b0;
      pc_load_q       <= 1'b0;
      pc_load_value_q <= 32'h0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      int_prev_q      <= int_prev_d;
      in_isr_q        <= in_isr_d;
      saved_pc_q      <= saved_pc_d;
      fd_enable_q     <= fd_enable_d;
      force_nop_q     <= force_nop_d;
      int_signal_q    <= int_signal_d;
      int_counter_q   <= int_counter_d;
      push_pc_q       <= push_pc_d;
      push_ccr_q      <= push_ccr_d;
      pc_load_q       <= pc_load_d;
      pc_load_value_q <= pc_load_value_d;
    end
  end

  assign bus.fd_enable     = fd_enable_q;
  assign bus.force_nop     = force_nop_q;
  assign bus.int_signal    = int_signal_q;
  assign bus.int_counter   = int_counter_q;
  assign bus.push_pc       = push_pc_q;
  assign bus.push_ccr      = push_ccr_q;
  assign bus.pc_load       = pc_load_q;
  assign bus.pc_load_value = pc_load_value_q;
  assign bus.saved_pc      = saved_pc_q;
  assign bus.in_isr        = in_isr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard and vector-table bench for interrupt_sequencer
module tb_interrupt_sequencer;

  // {fd_enable, force_nop, int_signal, int_counter[1:0], push_pc, push_ccr, pc_load, pc_load_value}
  typedef logic [39:0] out_t;
  typedef struct {
    int   cyc;
    out_t o;
  } sb_t;
  typedef struct {
    logic [2:0] mask;   // {branch_ex, call_busy, ret_busy}
    int         hold;   // edges the blockers stay high, starting with the request edge
    int         delay;  // expected edges from the request edge to acceptance
  } row_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  int   s, a, n;
  sb_t  sb[$];
  sb_t  ent;
  out_t mon_exp;
  out_t idle_o;
  out_t seq2[5];
  out_t seq3[6];
  row_t rows[5];

  interrupt_sequencer_if bus ();
  interrupt_sequencer_if bus3 ();

  interrupt_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  interrupt_sequencer #(.INT_VECTOR(32'h0000_0040), .DRAIN_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) bus.return_pc = 32'h0000_1000 + 32'(cyc * 4);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic out_t got_main();
    return {bus.fd_enable, bus.force_nop, bus.int_signal, bus.int_counter,
            bus.push_pc, bus.push_ccr, bus.pc_load, bus.pc_load_value};
  endfunction

  function automatic out_t got_d3();
    return {bus3.fd_enable, bus3.force_nop, bus3.int_signal, bus3.int_counter,
            bus3.push_pc, bus3.push_ccr, bus3.pc_load, bus3.pc_load_value};
  endfunction

  task automatic push_entry(input int start, input int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back('{start + i, seq2[i]});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = idle_o;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ent     = sb.pop_front();
        mon_exp = ent.o;
      end
      chk("strobes", 64'(got_main()), 64'(mon_exp));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    idle_o  = {8'b1_0_0_00_000, 32'h0};
    seq2[0] = {8'b0_1_1_00_000, 32'h0};
    seq2[1] = {8'b0_1_1_01_000, 32'h0};
    seq2[2] = {8'b0_1_1_10_100, 32'h0};
    seq2[3] = {8'b0_1_1_11_010, 32'h0};
    seq2[4] = {8'b1_1_0_00_001, 32'h1};
    seq3[0] = {8'b0_1_1_00_000, 32'h0};
    seq3[1] = {8'b0_1_1_01_000, 32'h0};
    seq3[2] = {8'b0_1_1_10_000, 32'h0};
    seq3[3] = {8'b0_1_1_10_100, 32'h0};
    seq3[4] = {8'b0_1_1_11_010, 32'h0};
    seq3[5] = {8'b1_1_0_00_001, 32'h40};
    rows[0] = '{3'b000, 0, 1};
    rows[1] = '{3'b100, 3, 3};
    rows[2] = '{3'b010, 1, 1};
    rows[3] = '{3'b001, 4, 4};
    rows[4] = '{3'b111, 2, 2};

    reset = 1'b1;
    bus.int_req = 1'b0; bus.branch_ex = 1'b0; bus.call_busy = 1'b0;
    bus.ret_busy = 1'b0; bus.rti_done = 1'b0;
    bus3.int_req = 1'b0; bus3.branch_ex = 1'b0; bus3.call_busy = 1'b0;
    bus3.ret_busy = 1'b0; bus3.rti_done = 1'b0; bus3.return_pc = 32'hABCD_0000;
    repeat (3) @(negedge clk);
    chk("reset_strobes", 64'(got_main()), 64'(idle_o));
    chk("reset_saved_pc", 64'(bus.saved_pc), 64'h0);
    chk("reset_in_isr", 64'(bus.in_isr), 64'h0);
    chk("reset_strobes_d3", 64'(got_d3()), 64'(idle_o));
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Blocker table; int_req stays high well past entry, so only one sequence may appear.
    for (int r = 0; r < 5; r++) begin
      bus.int_req = 1'b0;
      @(negedge clk);
      {bus.branch_ex, bus.call_busy, bus.ret_busy} = rows[r].mask;
      bus.int_req = 1'b1;
      s = cyc + 1;
      a = s + rows[r].delay;
      push_entry(a, 5);
      repeat (rows[r].hold) @(negedge clk);
      {bus.branch_ex, bus.call_busy, bus.ret_busy} = 3'b000;
      while (cyc < a + 5) @(negedge clk);
      chk("in_isr_set", 64'(bus.in_isr), 64'h1);
      chk("saved_pc", 64'(bus.saved_pc), 64'(32'h0000_1000 + 32'((a - 1) * 4)));
      repeat (12) @(negedge clk);
      bus.rti_done = 1'b1;
      @(negedge clk);
      bus.rti_done = 1'b0;
      chk("in_isr_clr", 64'(bus.in_isr), 64'h0);
      repeat (3) @(negedge clk);
    end

    // Nesting: a new edge during the ISR is held until rti_done, then taken one edge later.
    bus.int_req = 1'b0;
    @(negedge clk);
    bus.int_req = 1'b1;
    s = cyc + 1;
    a = s + 1;
    push_entry(a, 5);
    while (cyc < a + 5) @(negedge clk);
    chk("nest_in_isr", 64'(bus.in_isr), 64'h1);
    bus.int_req = 1'b0;
    @(negedge clk);
    bus.int_req = 1'b1;
    repeat (6) @(negedge clk);
    bus.rti_done = 1'b1;
    n = cyc + 1;
    push_entry(n + 1, 5);
    @(negedge clk);
    bus.rti_done = 1'b0;
    chk("nest_isr_clr", 64'(bus.in_isr), 64'h0);
    while (cyc < n + 6) @(negedge clk);
    chk("nest_in_isr2", 64'(bus.in_isr), 64'h1);
    chk("nest_saved_pc", 64'(bus.saved_pc), 64'(32'h0000_1000 + 32'(n * 4)));
    bus.rti_done = 1'b1;
    @(negedge clk);
    bus.rti_done = 1'b0;

    // Reset during PUSH_PC with int_req held high: no CCR push and no re-entry afterwards.
    bus.int_req = 1'b0;
    @(negedge clk);
    bus.int_req = 1'b1;
    s = cyc + 1;
    a = s + 1;
    push_entry(a, 3);
    while (cyc < a + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_in_isr", 64'(bus.in_isr), 64'h0);
    chk("rst_mid_saved_pc", 64'(bus.saved_pc), 64'h0);
    repeat (8) @(negedge clk);
    bus.int_req = 1'b0;
    @(negedge clk);
    bus.int_req = 1'b1;
    s = cyc + 1;
    push_entry(s + 1, 5);
    while (cyc < s + 6) @(negedge clk);
    chk("rst_recover_isr", 64'(bus.in_isr), 64'h1);
    bus.int_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'h0);

    // Three drain cycles: six-cycle entry with the custom vector.
    bus3.int_req = 1'b1;
    s = cyc + 1;
    a = s + 1;
    while (cyc < a) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("d3_step%0d", i), 64'(got_d3()), 64'(seq3[i]));
      @(negedge clk);
    end
    chk("d3_idle", 64'(got_d3()), 64'(idle_o));
    chk("d3_in_isr", 64'(bus3.in_isr), 64'h1);
    chk("d3_saved_pc", 64'(bus3.saved_pc), 64'h0000_0000_ABCD_0000);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
